uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Transmit-side front end of the UART. It buffers parallel bytes in a FIFO and
//  derives the 1/16 bit-rate enable from the 16x clock. It drives the
//  shiftLoad/parallelOut handshake into the UART transmitter, one frame per byte.
//  Upstream: host parallel port (load/dataIn). Downstream: UART transmitter (txEmpty back).
// PARAMETERS
//  WIDTH      8   payload bits per frame
//  DEPTH      4   FIFO entries; power of 2, >=2
//  DIV_PHASE  7   freqDiv value at which enable is asserted (0..15)
// PORTS
//  clock        in   1          16x clock; all state on posedge
//  reset        in   1          synchronous, active-high
//  load         in   1          push dataIn into FIFO this clock
//  dataIn       in   WIDTH      byte to push
//  full         out  1          FIFO holds DEPTH entries
//  empty        out  1          FIFO holds 0 entries
//  overrun      out  1          sticky: a push was dropped because FIFO was full
//  enable       out  1          bit-rate enable, 1 clock in 16
//  shiftLoad    out  1          0 = transmitter loads a frame on the next enable; 1 = shift
//  parallelOut  out  WIDTH      byte presented to the transmitter
//  txEmpty      in   1          transmitter idle (all bits sent)
//  level        out  log2(DEPTH)+1   FIFO occupancy (only with UART_TXF_LEVEL_EN)
// BEHAVIOUR
//  Reset: FIFO ptrs/count=0, full=0, empty=1, overrun=0, freqDiv=0, enable=0,
//   state=IDLE, shiftLoad=1, parallelOut=0. The reset edge discards FIFO contents and
//   any frame in progress. The transmitter is reset by the same reset, so there is no
//   partial frame to recover.
//  Divider: freqDiv 4-bit, increments every non-reset clock, wraps 15->0;
//   enable = (freqDiv==DIV_PHASE), combinational from the register.
//  Push: on a clock with load=1 and full=0, write dataIn at wr ptr.
//   On a clock with load=1 and full=1, drop the byte and set overrun; it stays set
//   until reset. full is the pre-edge value, so a push on a pop clock with full=1
//   is still dropped.
//  FSM (state, shiftLoad):
//   IDLE (1): on a clock with enable & txEmpty & !empty, latch head into parallelOut
//     and go to LOAD.
//   LOAD (0): hold parallelOut. On the next enable clock, the transmitter takes the
//     frame. On that same edge: pop the head, shiftLoad<=1, go to SEND.
//   SEND (1): wait. txEmpty is 0 from the clock after the load edge. Go to IDLE on
//     the first clock where txEmpty=1.
//  Latency: with an idle transmitter, a byte pushed into an empty FIFO reaches LOAD on
//   the first enable after it is visible, and is loaded on the following enable
//   (<=32 clocks).
//  Stop bit: because IDLE waits for an enable, the stop bit of the previous frame
//   lasts >=1 bit time between frames.
//  Wrap: ptrs are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//   Simultaneous push (not full) and pop leaves count unchanged.
//  A push into an empty FIFO is first visible (empty=0) the clock after the push.
// CONFIGURATION
//  `UART_TXF_LEVEL_EN defined: the level port exists and equals the FIFO count,
//   updated on the same edges as full/empty.
//  Undefined: no level port and no extra logic; all other behaviour is identical.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] {TXF_IDLE, TXF_LOAD, TXF_SEND} txf_state_t;
//   localparam DIV_BITS=4.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, sync
//   active-high reset, registered pointers, head combinational from mem[rd].
//  uart_tx_feeder instantiates it. The FSM, divider and overrun are local to uart_tx_feeder.
// TESTING
//  1 reset; push 8'hA5 with txEmpty=1 -> enable at freqDiv=7; shiftLoad=0 with
//    parallelOut=A5 until the next enable; pop there; empty=1.
//  2 push A5,3C,FF,00 (DEPTH=4) -> full=1. Push 11 -> dropped, overrun=1, level=4.
//    The four frames are sent in order.
//  3 full FIFO, push on the LOAD->SEND pop edge -> byte dropped, overrun=1, count=3.
//  4 assert reset while in LOAD -> next clock state=IDLE, shiftLoad=1, empty=1,
//    freqDiv=0, overrun=0.
//  5 loopback with the UART transmitter and receiver -> each received byte equals
//    the pushed byte; >=16 idle clocks of serial 1 between frames.
//  6 txEmpty held 0 -> FSM stays in IDLE/SEND, no pop, FIFO fills to full.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side front end.
package uart_pkg;

  localparam int DIV_BITS = 4;

  typedef enum logic [1:0] {
    TXF_IDLE = 2'd0,
    TXF_LOAD = 2'd1,
    TXF_SEND = 2'd2
  } txf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head read.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers wrap naturally; count carries the extra bit that tells full from empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// UART transmit front end: byte FIFO, 1/16 bit-rate enable and the shiftLoad handshake.
// Define UART_TXF_LEVEL_EN to add the FIFO occupancy port "level".
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DIV_PHASE = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [WIDTH-1:0]       dataIn,
  output logic                   full,
  output logic                   empty,
  output logic                   overrun,
  output logic                   enable,
  output logic                   shiftLoad,
  output logic [WIDTH-1:0]       parallelOut,
  input  logic                   txEmpty,
  output txf_state_t             state
`ifdef UART_TXF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [DIV_BITS-1:0] PHASE   = DIV_BITS'(DIV_PHASE);
  localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);

  txf_state_t          stateQ;
  txf_state_t          stateNext;
  logic [DIV_BITS-1:0] freqDiv;
  logic                latchHead;
  logic                popReq;
  logic [WIDTH-1:0]    fifoHead;
  logic                fifoFull;
  logic                fifoEmpty;

`ifndef UART_TXF_LEVEL_EN
  logic [PTR_W:0]      unusedCount;
`endif

  uart_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (load),
    .pushData (dataIn),
    .pop      (popReq),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
`ifdef UART_TXF_LEVEL_EN
    .count    (level)
`else
    .count    (unusedCount)
`endif
  );

  assign full   = fifoFull;
  assign empty  = fifoEmpty;
  assign enable = (freqDiv == PHASE);
  assign state  = stateQ;

  // Handshake: shiftLoad=0 offers parallelOut; the transmitter takes it on the
  // next enable edge, which is also the edge that pops the FIFO and raises shiftLoad.
  assign shiftLoad = (stateQ != TXF_LOAD);

  always_comb begin
    stateNext = stateQ;
    latchHead = 1'b0;
    popReq    = 1'b0;
    case (stateQ)
      TXF_IDLE: begin
        if (enable && txEmpty && !fifoEmpty) begin
          latchHead = 1'b1;
          stateNext = TXF_LOAD;
        end
      end
      TXF_LOAD: begin
        if (enable) begin
          popReq    = 1'b1;
          stateNext = TXF_SEND;
        end
      end
      TXF_SEND: begin
        if (txEmpty) begin
          stateNext = TXF_IDLE;
        end
      end
      default: begin
        stateNext = TXF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ      <= TXF_IDLE;
      freqDiv     <= '0;
      parallelOut <= '0;
      overrun     <= 1'b0;
    end else begin
      stateQ  <= stateNext;
      freqDiv <= freqDiv + DIV_ONE;
      if (latchHead) begin
        parallelOut <= fifoHead;
      end
      // full is the pre-edge value, so a push on a pop edge of a full FIFO is lost too.
      if (load && fifoFull) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed pushes, a transmitter model that captures
// each loaded frame, and a scoreboard queue of bytes expected on the serial side.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int DIV_PHASE = 7;
  localparam int MIN_GAP   = 11 * 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] dataIn;
  logic             full;
  logic             empty;
  logic             overrun;
  logic             enable;
  logic             shiftLoad;
  logic [WIDTH-1:0] parallelOut;
  logic             txEmpty;
  txf_state_t       state;
`ifdef UART_TXF_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  uart_tx_feeder #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .DIV_PHASE (DIV_PHASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .dataIn      (dataIn),
    .full        (full),
    .empty       (empty),
    .overrun     (overrun),
    .enable      (enable),
    .shiftLoad   (shiftLoad),
    .parallelOut (parallelOut),
    .txEmpty     (txEmpty),
    .state       (state)
`ifdef UART_TXF_LEVEL_EN
    ,
    .level       (level)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               modelCount = 0;
  logic             popPending = 1'b0;
  logic             expOverrun = 1'b0;
  logic             txBusy = 1'b0;
  logic             txHold = 1'b0;
  int               bitCnt = 0;
  int               cycleCount = 0;
  int               lastLoadCycle = 0;
  logic             lastLoadValid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model occupancy drops on the pop edge itself, after the push decision at the prior negedge.
  always @(posedge clock) begin
    cycleCount++;
    if (popPending) begin
      modelCount--;
      popPending = 1'b0;
    end
  end

  // Transmitter model and scoreboard monitor: a frame is taken when the next edge is
  // an enable edge and shiftLoad=0; it then occupies 10 bit times.
  always @(negedge clock) begin
    if (reset) begin
      txBusy = 1'b0;
      bitCnt = 0;
    end else if (enable) begin
      if (!txBusy && !shiftLoad) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: unexpected byte %0h", parallelOut);
        end else begin
          check("frame", 32'(parallelOut), 32'(exp_q.pop_front()));
        end
        if (lastLoadValid) begin
          check("frame gap", 32'(cycleCount - lastLoadCycle >= MIN_GAP), 32'd1);
        end
        lastLoadCycle = cycleCount;
        lastLoadValid = 1'b1;
        popPending    = 1'b1;
        txBusy        = 1'b1;
        bitCnt        = 0;
      end else if (txBusy) begin
        bitCnt++;
        if (bitCnt == 10) begin
          txBusy = 1'b0;
        end
      end
    end
    txEmpty = !txBusy && !txHold;
  end

  // driver tasks
  task automatic apply_reset_now();
    reset         = 1'b1;
    load          = 1'b0;
    exp_q.delete();
    modelCount    = 0;
    popPending    = 1'b0;
    expOverrun    = 1'b0;
    lastLoadValid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    while (enable) @(negedge clock);
    apply_reset_now();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Called right after a negedge; returns at the following negedge.
  task automatic push(input logic [WIDTH-1:0] b);
    load   = 1'b1;
    dataIn = b;
    if (modelCount < DEPTH) begin
      exp_q.push_back(b);
      modelCount++;
    end else begin
      expOverrun = 1'b1;
    end
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || txBusy) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check({name, " drained"}, 32'(exp_q.size() == 0 && !txBusy), 32'd1);
    check({name, " empty"}, 32'(empty), 32'd1);
    check({name, " overrun"}, 32'(overrun), 32'(expOverrun));
  endtask

  task automatic check_reset_state(input string name);
    check({name, " full"}, 32'(full), 32'd0);
    check({name, " empty"}, 32'(empty), 32'd1);
    check({name, " overrun"}, 32'(overrun), 32'd0);
    check({name, " enable"}, 32'(enable), 32'd0);
    check({name, " shiftLoad"}, 32'(shiftLoad), 32'd1);
    check({name, " parallelOut"}, 32'(parallelOut), 32'd0);
    check({name, " state"}, 32'(state), 32'(TXF_IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b1;
    load    = 1'b0;
    dataIn  = '0;
    txEmpty = 1'b1;

    // 1: single byte, enable phase and period, load handshake
    repeat (2) @(negedge clock);
    check_reset_state("t1 reset");
    reset = 1'b0;
    push(8'hA5);
    check("t1 empty after push", 32'(empty), 32'd0);
    n = 1;
    while (!enable && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("t1 first enable", 32'(n), 32'd7);
    @(negedge clock);
    check("t1 shiftLoad", 32'(shiftLoad), 32'd0);
    check("t1 parallelOut", 32'(parallelOut), 32'hA5);
    check("t1 state", 32'(state), 32'(TXF_LOAD));
    n = 1;
    while (!enable && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("t1 enable period", 32'(n), 32'd16);
    check("t1 shiftLoad held", 32'(shiftLoad), 32'd0);
    @(negedge clock);
    check("t1 empty after pop", 32'(empty), 32'd1);
    check("t1 shiftLoad after pop", 32'(shiftLoad), 32'd1);
    check("t1 state after pop", 32'(state), 32'(TXF_SEND));
    drain("t1");

    // 2: fill, overflow, frames in order
    do_reset();
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    push(8'h00);
    check("t2 full", 32'(full), 32'd1);
    push(8'h11);
    check("t2 overrun", 32'(overrun), 32'd1);
    check("t2 full kept", 32'(full), 32'd1);
`ifdef UART_TXF_LEVEL_EN
    check("t2 level", 32'(level), 32'd4);
`endif
    drain("t2");

    // 3: push on the pop edge of a full FIFO is dropped
    do_reset();
    push(8'h12);
    push(8'h34);
    push(8'h56);
    push(8'h78);
    n = 0;
    while (!(enable && !shiftLoad) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t3 reached pop edge", 32'(n < 100), 32'd1);
    push(8'h99);
    check("t3 overrun", 32'(overrun), 32'd1);
    check("t3 full after pop", 32'(full), 32'd0);
`ifdef UART_TXF_LEVEL_EN
    check("t3 level", 32'(level), 32'd3);
`endif
    drain("t3");

    // 4: reset while in LOAD, then loopback of two more bytes
    do_reset();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h05);
    n = 0;
    while (!(!shiftLoad && !enable) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t4 reached LOAD", 32'(n < 100), 32'd1);
    check("t4 overrun before reset", 32'(overrun), 32'd1);
    apply_reset_now();
    @(negedge clock);
    check_reset_state("t4 reset");
    reset = 1'b0;
    n = 0;
    while (!enable && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("t4 first enable", 32'(n), 32'd7);
    push(8'h5A);
    push(8'hC3);
    drain("t4");

    // 6: transmitter never idle, FIFO fills, nothing is offered
    txHold = 1'b1;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push(8'h40 + 8'(i));
      repeat (19) @(negedge clock);
      check("t6 shiftLoad", 32'(shiftLoad), 32'd1);
      check("t6 state", 32'(state), 32'(TXF_IDLE));
    end
    check("t6 full", 32'(full), 32'd1);
    check("t6 overrun", 32'(overrun), 32'd0);
    txHold = 1'b0;
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
